scalar_writeback_arbiter: RTL



---
 rtl/scalar_wb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 65 ++++++
 rtl/scalar_writeback_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/scalar_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scalar_wb_pkg
//  Description : Shared types and constants for the scalar register-file
//                write side. It provides the default data and register-index
//                widths, the largest supported source count, and a writeback
//                request struct {addr, data}.
//  Revision    : 1.0 - initial release
// ============================================================================
package scalar_wb_pkg;

    localparam int SCALAR_DATA_W = 36;
    localparam int SCALAR_ADDR_W = 5;
    localparam int WB_MAX_SRC    = 8;

    typedef struct packed {
        logic [SCALAR_ADDR_W-1:0] addr;
        logic [SCALAR_DATA_W-1:0] data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Rotating-priority arbiter. On each cycle it grants the first
//                request found at or after the priority pointer. The pointer
//                moves to the index after the winner, and it moves only when
//                a grant is issued.
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset (pointer -> 0)
//                req  - N-bit request vector
//                gnt  - N-bit one-hot grant (combinational, zero if no req)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int             PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W:0] c_n   = (PTR_W+1)'(N);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        logic           found;
        logic [PTR_W:0] idx;
        logic [PTR_W:0] nxt;
        found = 1'b0;
        idx   = '0;
        nxt   = '0;
        gnt   = '0;
        ptr_d = ptr_q;
        for (int k = 0; k < N; k++) begin
            // ptr_q < N and k < N, so one conditional subtract gives the modulo.
            idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (idx >= c_n) begin
                idx = idx - c_n;
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                found                = 1'b1;
                gnt[idx[PTR_W-1:0]] = 1'b1;
                nxt                  = idx + (PTR_W+1)'(1);
                if (nxt >= c_n) begin
                    nxt = '0;
                end
                ptr_d = nxt[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scalar_writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : scalar_writeback_arbiter
//  Description : Write side of the scalar register file. Each producing unit
//                has a one-entry result buffer. A round-robin arbiter drains
//                the full buffers onto the single registered write port. The
//                block also reports, for decode interlock, whether a queried
//                register still has a result buffered here.
//  Ports       : clk, rst            - clock, async active-high reset
//                src_valid/src_ready - per-unit handshake
//                src_addr/src_data   - per-unit destination and result (flat)
//                we/write_addr/_data - registered register-file write port
//                pend_addr1/2        - decode query indices
//                pend_hit1/2         - query matches a full buffer (comb)
//  Options     : SCALAR_WB_R0_DISCARD_EN - results for r0 are accepted but
//                dropped. They are never buffered and never written.
//  Revision    : 1.0 - initial release
// ============================================================================
module scalar_writeback_arbiter
    import scalar_wb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = SCALAR_DATA_W,
    parameter int ADDR_W  = SCALAR_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic                      we,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data,
    input  logic [ADDR_W-1:0]         pend_addr1,
    input  logic [ADDR_W-1:0]         pend_addr2,
    output logic                      pend_hit1,
    output logic                      pend_hit2
);

    logic [NUM_SRC-1:0] buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0]  buf_addr_q [NUM_SRC];
    logic [ADDR_W-1:0]  buf_addr_d [NUM_SRC];
    logic [DATA_W-1:0]  buf_data_q [NUM_SRC];
    logic [DATA_W-1:0]  buf_data_d [NUM_SRC];

    logic               we_q, we_d;
    logic [ADDR_W-1:0]  write_addr_q, write_addr_d;
    logic [DATA_W-1:0]  write_data_q, write_data_d;

    logic [NUM_SRC-1:0] w_gnt;
    logic [NUM_SRC-1:0] w_hs;
    logic [NUM_SRC-1:0] w_keep;
    logic [ADDR_W-1:0]  w_src_addr [NUM_SRC];
    logic [DATA_W-1:0]  w_src_data [NUM_SRC];
    logic [ADDR_W-1:0]  w_win_addr;
    logic [DATA_W-1:0]  w_win_data;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_src_addr[gi] = src_addr[gi*ADDR_W +: ADDR_W];
            assign w_src_data[gi] = src_data[gi*DATA_W +: DATA_W];
`ifdef SCALAR_WB_R0_DISCARD_EN
            // r0 results complete the handshake but are dropped here.
            assign w_keep[gi]     = |w_src_addr[gi];
`else
            assign w_keep[gi]     = 1'b1;
`endif
        end
    endgenerate

    // A buffer being drained this cycle can take a new result in the same edge.
    assign src_ready = ~buf_valid_q | w_gnt;
    assign w_hs      = src_valid & src_ready;

    rr_arbiter #(
        .N   (NUM_SRC)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (buf_valid_q),
        .gnt (w_gnt)
    );

    always_comb begin
        buf_valid_d = (buf_valid_q & ~w_gnt) | (w_hs & w_keep);
        w_win_addr  = '0;
        w_win_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            buf_addr_d[i] = buf_addr_q[i];
            buf_data_d[i] = buf_data_q[i];
            if (w_hs[i] && w_keep[i]) begin
                buf_addr_d[i] = w_src_addr[i];
                buf_data_d[i] = w_src_data[i];
            end
            // The grant is one-hot, so an OR-mux selects the winner.
            if (w_gnt[i]) begin
                w_win_addr = w_win_addr | buf_addr_q[i];
                w_win_data = w_win_data | buf_data_q[i];
            end
        end
        we_d         = |w_gnt;
        write_addr_d = we_d ? w_win_addr : write_addr_q;
        write_data_d = we_d ? w_win_data : write_data_q;
    end

    // The output register is left out on purpose: the register-file bypass
    // already covers a result that is being written this cycle.
    always_comb begin
        pend_hit1 = 1'b0;
        pend_hit2 = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (buf_valid_q[i] && (buf_addr_q[i] == pend_addr1)) begin
                pend_hit1 = 1'b1;
            end
            if (buf_valid_q[i] && (buf_addr_q[i] == pend_addr2)) begin
                pend_hit2 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                buf_addr_q[i] <= '0;
                buf_data_q[i] <= '0;
            end
            we_q         <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                buf_addr_q[i] <= buf_addr_d[i];
                buf_data_q[i] <= buf_data_d[i];
            end
            we_q         <= we_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign we         = we_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;

endmodule
`default_nettype wire
